// File: rtl/irrigation_scheduler.sv
// Round-robin irrigation scheduler: opens one zone valve at a time for a timed
// duration, inserts a settle gap, and shows the active zone on a 7-seg digit.
module irrigation_scheduler #(
  parameter int NAREAS     = 4,
  parameter int NBITS_TIME = 4,
  parameter int PRESCALE   = 4,
  parameter int GAP_CYCLES = 2,
  localparam int AW        = (NAREAS > 1) ? $clog2(NAREAS) : 1
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NAREAS-1:0]     req,
  input  logic [NBITS_TIME-1:0] duration,
  output logic [NAREAS-1:0]     valve,
  output logic [AW-1:0]         cur_area,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            seg
);

  // state | meaning
  // IDLE  | all valves closed, waiting for enable and a request
  // WATER | one valve open, prescaler/timer running
  // GAP   | valves closed for GAP_CYCLES cycles before the next grant
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATER = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                  state_q, state_d;
  logic [NAREAS-1:0]       valve_q, valve_d;
  logic [AW-1:0]           cur_area_q, cur_area_d;
  logic [AW-1:0]           last_grant_q, last_grant_d;
  logic [NBITS_TIME-1:0]   timer_q, timer_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [7:0]              seg_q, seg_d;

  logic                    grant_found;
  logic [AW-1:0]           grant_idx;
  logic                    tick;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = 8'h7E;
      4'd1:    pat = 8'h30;
      4'd2:    pat = 8'h6D;
      4'd3:    pat = 8'h79;
      4'd4:    pat = 8'h33;
      4'd5:    pat = 8'h5B;
      4'd6:    pat = 8'h5F;
      4'd7:    pat = 8'h70;
      4'd8:    pat = 8'h7F;
      4'd9:    pat = 8'h7B;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  // Search starts one past the last grant so every requesting zone gets a turn.
  always_comb begin
    int            idx_int;
    logic [AW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_int     = 0;
    idx         = '0;
    for (int i = 1; i <= NAREAS; i++) begin
      idx_int = int'(last_grant_q) + i;
      if (idx_int >= NAREAS) begin
        idx_int = idx_int - NAREAS;
      end
      idx = AW'(idx_int);
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign tick = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    state_d      = state_q;
    valve_d      = valve_q;
    cur_area_d   = cur_area_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    presc_d      = presc_q;
    gap_d        = gap_q;
    done_d       = 1'b0;
    seg_d        = seg_q;

    case (state_q)
      IDLE: begin
        if (enable && grant_found) begin
          state_d      = WATER;
          valve_d      = NAREAS'(1) << grant_idx;
          cur_area_d   = grant_idx;
          last_grant_d = grant_idx;
          timer_d      = (duration == '0) ? NBITS_TIME'(1) : duration;
          presc_d      = '0;
          seg_d        = seg_encode(4'(grant_idx));
        end
      end

      WATER: begin
        if (!enable) begin
          state_d = GAP;
          valve_d = '0;
          seg_d   = 8'h00;
          presc_d = '0;
          gap_d   = GW'(GAP_CYCLES - 1);
        end else if (tick) begin
          presc_d = '0;
          if (timer_q == NBITS_TIME'(1)) begin
            state_d = GAP;
            valve_d = '0;
            seg_d   = 8'h00;
            done_d  = 1'b1;
            gap_d   = GW'(GAP_CYCLES - 1);
          end else begin
            timer_d = timer_q - NBITS_TIME'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        valve_d = '0;
        seg_d   = 8'h00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valve_q      <= '0;
      cur_area_q   <= '0;
      last_grant_q <= AW'(NAREAS - 1);
      timer_q      <= '0;
      presc_q      <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      seg_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      valve_q      <= valve_d;
      cur_area_q   <= cur_area_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      presc_q      <= presc_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      seg_q        <= seg_d;
    end
  end

  assign valve    = valve_q;
  assign cur_area = cur_area_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign seg      = seg_q;

endmodule
